// File: rtl/local_flit_injector_if.sv
// local_flit_injector_if: NoC flit format plus the tile/router-facing signal bundle of the local injector.
package noc_params;
  localparam int DEST_ADDR_SIZE_X = 4;
  localparam int DEST_ADDR_SIZE_Y = 4;
  localparam int FLIT_DATA_SIZE = 16;
  localparam int VC_SIZE = 1;
  localparam int HEAD_PAYLOAD_SIZE = FLIT_DATA_SIZE - DEST_ADDR_SIZE_X - DEST_ADDR_SIZE_Y;
  typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;
  typedef struct packed {
    logic [DEST_ADDR_SIZE_X-1:0] x_dest;
    logic [DEST_ADDR_SIZE_Y-1:0] y_dest;
    logic [HEAD_PAYLOAD_SIZE-1:0] head_pl;
  } head_data_t;
  typedef union packed {
    head_data_t head_data;
    logic [FLIT_DATA_SIZE-1:0] bt_pl;
  } flit_data_t;
  typedef struct packed {
    flit_label_t flit_label;
    logic [VC_SIZE-1:0] vc_id;
    flit_data_t data;
  } flit_t;
endpackage

interface local_flit_injector_if #(parameter int VC_NUM = 2, parameter int LEN_W = 5);
  import noc_params::*;
  logic pkt_valid_i;
  logic pkt_ready_o;
  logic [DEST_ADDR_SIZE_X-1:0] pkt_dest_x_i;
  logic [DEST_ADDR_SIZE_Y-1:0] pkt_dest_y_i;
  logic [LEN_W-1:0] pkt_len_i;
  logic pl_valid_i;
  logic pl_ready_o;
  logic [FLIT_DATA_SIZE-1:0] pl_data_i;
  flit_t data_o;
  logic valid_flit_o;
  logic [VC_NUM-1:0] on_off_i;
  logic [VC_NUM-1:0] is_allocatable_i;
  logic [15:0] pkts_sent_o;
  logic err_len_o;
  modport master (
    output pkt_valid_i, pkt_dest_x_i, pkt_dest_y_i, pkt_len_i, pl_valid_i, pl_data_i,
           on_off_i, is_allocatable_i,
    input pkt_ready_o, pl_ready_o, data_o, valid_flit_o, pkts_sent_o, err_len_o
  );
  modport slave (
    input pkt_valid_i, pkt_dest_x_i, pkt_dest_y_i, pkt_len_i, pl_valid_i, pl_data_i,
          on_off_i, is_allocatable_i,
    output pkt_ready_o, pl_ready_o, data_o, valid_flit_o, pkts_sent_o, err_len_o
  );
endinterface

// File: rtl/local_flit_injector.sv
// local_flit_injector: segments tile packets into HEAD/BODY/TAIL flits on a round-robin claimed VC under on_off backpressure.
module local_flit_injector #(
  parameter int VC_NUM = 2,
  parameter int MAX_PKT_LEN = 16,
  localparam int LEN_W = $clog2(MAX_PKT_LEN + 1)
) (
  input logic clk,
  input logic rst,
  local_flit_injector_if.slave bus
);
  import noc_params::*;
  typedef enum logic [1:0] {IDLE, VC_SEL, SEND} state_t;
  state_t state, state_d;
  logic [DEST_ADDR_SIZE_X-1:0] dest_x;
  logic [DEST_ADDR_SIZE_Y-1:0] dest_y;
  logic [LEN_W-1:0] len, remaining;
  logic [VC_SIZE-1:0] cur_vc, rr_ptr, grant_vc, rr_next;
  logic [VC_SIZE:0] sum;
  logic [2*VC_NUM-1:0] dbl;
  logic [VC_NUM-1:0] rot;
  logic grant, issue, first;
  flit_t flit;
  assign bus.pkt_ready_o = state == IDLE && !rst;
  assign issue = state == SEND && bus.pl_valid_i && bus.on_off_i[cur_vc];
  assign bus.pl_ready_o = issue;
  assign first = remaining == len;
  // rotate so bit 0 is the VC at rr_ptr; the lowest set bit of rot wins
  always_comb begin
    dbl = {bus.is_allocatable_i, bus.is_allocatable_i} >> rr_ptr;
    rot = dbl[VC_NUM-1:0];
    grant = 1'b0;
    sum = '0;
    for (int i = VC_NUM - 1; i >= 0; i--)
      if (rot[i]) begin
        grant = 1'b1;
        sum = {1'b0, rr_ptr} + (VC_SIZE + 1)'(i);
      end
    grant_vc = sum >= (VC_SIZE + 1)'(VC_NUM) ? VC_SIZE'(sum - (VC_SIZE + 1)'(VC_NUM)) : VC_SIZE'(sum);
    rr_next = grant_vc == VC_SIZE'(VC_NUM - 1) ? '0 : grant_vc + 1'b1;
  end
  always_comb begin
    flit.flit_label = first ? (len == LEN_W'(1) ? HEADTAIL : HEAD)
                            : (remaining == LEN_W'(1) ? TAIL : BODY);
    flit.vc_id = cur_vc;
    flit.data = first ? flit_data_t'({dest_x, dest_y, bus.pl_data_i[HEAD_PAYLOAD_SIZE-1:0]})
                      : flit_data_t'(bus.pl_data_i);
  end
  always_comb begin
    state_d = state;
    case (state)
      IDLE: state_d = bus.pkt_valid_i && bus.pkt_len_i != '0 ? VC_SEL : IDLE;
      VC_SEL: state_d = grant ? SEND : VC_SEL;
      SEND: state_d = issue && remaining == LEN_W'(1) ? IDLE : SEND;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dest_x <= '0;
      dest_y <= '0;
      len <= '0;
      remaining <= '0;
      cur_vc <= '0;
      rr_ptr <= '0;
      bus.data_o <= '0;
      bus.valid_flit_o <= 1'b0;
      bus.pkts_sent_o <= '0;
      bus.err_len_o <= 1'b0;
    end else begin
      bus.err_len_o <= state == IDLE && bus.pkt_valid_i && bus.pkt_len_i == '0;
      bus.valid_flit_o <= issue;
      if (state == IDLE && bus.pkt_valid_i) begin
        dest_x <= bus.pkt_dest_x_i;
        dest_y <= bus.pkt_dest_y_i;
        len <= bus.pkt_len_i;
        remaining <= bus.pkt_len_i;
      end
      if (state == VC_SEL && grant) begin
        cur_vc <= grant_vc;
        rr_ptr <= rr_next;
      end
      if (issue) begin
        bus.data_o <= flit;
        remaining <= remaining - 1'b1;
        if (remaining == LEN_W'(1)) bus.pkts_sent_o <= bus.pkts_sent_o + 1'b1;
      end
    end
endmodule
